ra_4r2w_64x72_ddr: RTL and testbench

RA_4R2W_64X72_DDR -- requirements
Module: ra_4r2w_64x72_ddr

---
 rtl/ra_4r2w_64x72_ddr_pkg.sv | 12 +
 rtl/ra_4r2w_64x72_ddr_if.sv | 17 +
 rtl/ra_rdport_ddr.sv | 44 ++++
 rtl/ra_4r2w_64x72_ddr.sv | 92 +++++++++
 tb/tb_ra_4r2w_64x72_ddr.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ra_4r2w_64x72_ddr_pkg.sv
// Shared toysram geometry defaults, used by the array, its BIST and its config block.
package ra_4r2w_64x72_ddr_pkg;

   localparam int WORDS_DEF = 64;
   localparam int WIDTH_DEF = 72;
   localparam int ADRW_DEF  = 6;

   localparam int N_RD_PORTS = 4;
   // Read ports 0..EARLY_RD_PORTS-1 belong to the early element, the rest to the late one.
   localparam int EARLY_RD_PORTS = 2;

endpackage

// File: rtl/ra_4r2w_64x72_ddr_if.sv
// One read port of the toysram array: enable and address in, registered word out.
interface ra_4r2w_64x72_ddr_if
   import ra_4r2w_64x72_ddr_pkg::*;
#(
   parameter int ADRW  = ADRW_DEF,
   parameter int WIDTH = WIDTH_DEF
);

   // No ready: enb is sampled at the rising edge of an executing cycle; dat then holds until the next executing enb.
   logic             enb;
   logic [0:ADRW-1]  adr;
   logic [0:WIDTH-1] dat;

   modport master (output enb, output adr, input dat);
   modport slave  (input enb, input adr, output dat);

endinterface

// File: rtl/ra_rdport_ddr.sv
// Registered read mux for one array port, with optional same-edge bypass of the early write.
module ra_rdport_ddr
   import ra_4r2w_64x72_ddr_pkg::*;
#(
   parameter int WORDS = WORDS_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int ADRW  = ADRW_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 exec,
   input  logic [0:WIDTH-1]     mem [WORDS],
   input  logic                 byp_en,
   input  logic [0:ADRW-1]      byp_adr,
   input  logic [0:WIDTH-1]     byp_dat,
   ra_4r2w_64x72_ddr_if.slave   port
);

   logic [0:WIDTH-1] dat_d;
   logic [0:WIDTH-1] dat_q;

   always_comb begin
      dat_d = dat_q;
      if (exec && port.enb) begin
         // Late ports see the early write of the same edge ahead of storage.
         if (byp_en && (byp_adr == port.adr)) begin
            dat_d = byp_dat;
         end else begin
            dat_d = mem[port.adr];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dat_q <= '0;
      end else begin
         dat_q <= dat_d;
      end
   end

   assign port.dat = dat_q;

endmodule

// File: rtl/ra_4r2w_64x72_ddr.sv
// 64x72 register array, four read and two write ports split into early and late elements.
module ra_4r2w_64x72_ddr
   import ra_4r2w_64x72_ddr_pkg::*;
#(
   parameter int WORDS = WORDS_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int ADRW  = ADRW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic             el_sel,
   input  logic             rd_enb_0,
   input  logic             rd_enb_1,
   input  logic             rd_enb_2,
   input  logic             rd_enb_3,
   input  logic [0:ADRW-1]  rd_adr_0,
   input  logic [0:ADRW-1]  rd_adr_1,
   input  logic [0:ADRW-1]  rd_adr_2,
   input  logic [0:ADRW-1]  rd_adr_3,
   output logic [0:WIDTH-1] rd_dat_0,
   output logic [0:WIDTH-1] rd_dat_1,
   output logic [0:WIDTH-1] rd_dat_2,
   output logic [0:WIDTH-1] rd_dat_3,
   input  logic             wr_enb_0,
   input  logic             wr_enb_1,
   input  logic [0:ADRW-1]  wr_adr_0,
   input  logic [0:ADRW-1]  wr_adr_1,
   input  logic [0:WIDTH-1] wr_dat_0,
   input  logic [0:WIDTH-1] wr_dat_1
);

   logic [0:WIDTH-1] mem_q [WORDS];
   logic             early_go;
   logic             late_go;
   logic             wr0_go;
   logic             wr1_go;

   always_comb begin
      early_go = strobe;
      late_go  = strobe && el_sel;
      wr0_go   = early_go && wr_enb_0;
      wr1_go   = late_go && wr_enb_1;
   end

   // Storage is never cleared; reset only blocks writes. wr1 lands after wr0 so it wins a collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (wr0_go) begin
            mem_q[wr_adr_0] <= wr_dat_0;
         end
         if (wr1_go) begin
            mem_q[wr_adr_1] <= wr_dat_1;
         end
      end
   end

   ra_4r2w_64x72_ddr_if #(.ADRW(ADRW), .WIDTH(WIDTH)) rd_if [N_RD_PORTS] ();

   assign rd_if[0].enb = rd_enb_0;
   assign rd_if[1].enb = rd_enb_1;
   assign rd_if[2].enb = rd_enb_2;
   assign rd_if[3].enb = rd_enb_3;
   assign rd_if[0].adr = rd_adr_0;
   assign rd_if[1].adr = rd_adr_1;
   assign rd_if[2].adr = rd_adr_2;
   assign rd_if[3].adr = rd_adr_3;
   assign rd_dat_0     = rd_if[0].dat;
   assign rd_dat_1     = rd_if[1].dat;
   assign rd_dat_2     = rd_if[2].dat;
   assign rd_dat_3     = rd_if[3].dat;

   for (genvar g = 0; g < N_RD_PORTS; g++) begin : g_rd
      localparam bit IS_LATE = (g >= EARLY_RD_PORTS);

      ra_rdport_ddr #(
         .WORDS (WORDS),
         .WIDTH (WIDTH),
         .ADRW  (ADRW)
      ) u_rdport (
         .clk     (clk),
         .reset   (reset),
         .exec    (IS_LATE ? late_go : early_go),
         .mem     (mem_q),
         .byp_en  (IS_LATE && wr0_go),
         .byp_adr (wr_adr_0),
         .byp_dat (wr_dat_0),
         .port    (rd_if[g])
      );
   end

endmodule

// File: tb/tb_ra_4r2w_64x72_ddr.sv
// Directed bench for the 4R2W array: element gating, in-edge ordering, strobe and reset behaviour.
module tb_ra_4r2w_64x72_ddr;

   localparam int WORDS = 64;
   localparam int WIDTH = 72;
   localparam int ADRW  = 6;

   logic             clk;
   logic             reset;
   logic             strobe;
   logic             el_sel;
   logic             rd_enb_0, rd_enb_1, rd_enb_2, rd_enb_3;
   logic [0:ADRW-1]  rd_adr_0, rd_adr_1, rd_adr_2, rd_adr_3;
   logic [0:WIDTH-1] rd_dat_0, rd_dat_1, rd_dat_2, rd_dat_3;
   logic             wr_enb_0, wr_enb_1;
   logic [0:ADRW-1]  wr_adr_0, wr_adr_1;
   logic [0:WIDTH-1] wr_dat_0, wr_dat_1;

   int errors = 0;
   int checks = 0;

   localparam logic [0:WIDTH-1] D04  = 72'h040404040404040404;
   localparam logic [0:WIDTH-1] D08  = 72'h080808080808080808;
   localparam logic [0:WIDTH-1] D02  = 72'h020202020202020202;
   localparam logic [0:WIDTH-1] D55  = 72'h555555555555555555;
   localparam logic [0:WIDTH-1] D33  = 72'h333333333333333333;
   localparam logic [0:WIDTH-1] DA5  = 72'hA5A5A5A5A5A5A5A5A5;
   localparam logic [0:WIDTH-1] DA   = 72'h0123456789ABCDEF01;
   localparam logic [0:WIDTH-1] DB   = 72'hFEDCBA9876543210FE;
   localparam logic [0:WIDTH-1] DFF  = 72'hFFFFFFFFFFFFFFFFFF;

   ra_4r2w_64x72_ddr #(.WORDS(WORDS), .WIDTH(WIDTH), .ADRW(ADRW)) dut (
      .clk      (clk),
      .reset    (reset),
      .strobe   (strobe),
      .el_sel   (el_sel),
      .rd_enb_0 (rd_enb_0),
      .rd_enb_1 (rd_enb_1),
      .rd_enb_2 (rd_enb_2),
      .rd_enb_3 (rd_enb_3),
      .rd_adr_0 (rd_adr_0),
      .rd_adr_1 (rd_adr_1),
      .rd_adr_2 (rd_adr_2),
      .rd_adr_3 (rd_adr_3),
      .rd_dat_0 (rd_dat_0),
      .rd_dat_1 (rd_dat_1),
      .rd_dat_2 (rd_dat_2),
      .rd_dat_3 (rd_dat_3),
      .wr_enb_0 (wr_enb_0),
      .wr_enb_1 (wr_enb_1),
      .wr_adr_0 (wr_adr_0),
      .wr_adr_1 (wr_adr_1),
      .wr_dat_0 (wr_dat_0),
      .wr_dat_1 (wr_dat_1)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic clr();
      strobe   = 1'b0;
      el_sel   = 1'b0;
      rd_enb_0 = 1'b0;
      rd_enb_1 = 1'b0;
      rd_enb_2 = 1'b0;
      rd_enb_3 = 1'b0;
      wr_enb_0 = 1'b0;
      wr_enb_1 = 1'b0;
      rd_adr_0 = '0;
      rd_adr_1 = '0;
      rd_adr_2 = '0;
      rd_adr_3 = '0;
      wr_adr_0 = '0;
      wr_adr_1 = '0;
      wr_dat_0 = '0;
      wr_dat_1 = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clr();
      tick();
      tick();
      checks++; if (rd_dat_0 !== '0) begin errors++; $display("FAIL reset_rd0 got=%h exp=%h", rd_dat_0, 72'h0); end
      checks++; if (rd_dat_1 !== '0) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", rd_dat_1, 72'h0); end
      checks++; if (rd_dat_2 !== '0) begin errors++; $display("FAIL reset_rd2 got=%h exp=%h", rd_dat_2, 72'h0); end
      checks++; if (rd_dat_3 !== '0) begin errors++; $display("FAIL reset_rd3 got=%h exp=%h", rd_dat_3, 72'h0); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_early_write();
      logic [7:0] a8;
      for (int i = 0; i < 5; i++) begin
         a8       = 8'(2 * i);
         clr();
         strobe   = 1'b1;
         wr_enb_0 = 1'b1;
         wr_adr_0 = 6'(2 * i);
         wr_dat_0 = {9{a8}};
         tick();
      end
      clr();
      strobe   = 1'b1;
      rd_enb_0 = 1'b1;
      rd_adr_0 = 6'd4;
      rd_enb_1 = 1'b1;
      rd_adr_1 = 6'd8;
      tick();
      checks++; if (rd_dat_0 !== D04) begin errors++; $display("FAIL early_rd0_adr4 got=%h exp=%h", rd_dat_0, D04); end
      checks++; if (rd_dat_1 !== D08) begin errors++; $display("FAIL early_rd1_adr8 got=%h exp=%h", rd_dat_1, D08); end
   endtask

   task automatic test_late_suppress();
      clr();
      strobe   = 1'b1;
      wr_enb_0 = 1'b1;
      wr_adr_0 = 6'd5;
      wr_dat_0 = D55;
      tick();
      clr();
      strobe   = 1'b1;
      wr_enb_1 = 1'b1;
      wr_adr_1 = 6'd5;
      wr_dat_1 = 72'h1;
      rd_enb_2 = 1'b1;
      rd_adr_2 = 6'd5;
      tick();
      checks++; if (rd_dat_2 !== '0) begin errors++; $display("FAIL late_rd2_suppressed got=%h exp=%h", rd_dat_2, 72'h0); end
      clr();
      strobe   = 1'b1;
      el_sel   = 1'b1;
      rd_enb_2 = 1'b1;
      rd_adr_2 = 6'd5;
      tick();
      checks++; if (rd_dat_2 !== D55) begin errors++; $display("FAIL late_wr1_suppressed got=%h exp=%h", rd_dat_2, D55); end
   endtask

   task automatic test_bypass();
      clr();
      strobe   = 1'b1;
      wr_enb_0 = 1'b1;
      wr_adr_0 = 6'd3;
      wr_dat_0 = D33;
      tick();
      clr();
      strobe   = 1'b1;
      el_sel   = 1'b1;
      wr_enb_0 = 1'b1;
      wr_adr_0 = 6'd3;
      wr_dat_0 = DA5;
      rd_enb_0 = 1'b1;
      rd_adr_0 = 6'd3;
      rd_enb_2 = 1'b1;
      rd_adr_2 = 6'd3;
      tick();
      checks++; if (rd_dat_2 !== DA5) begin errors++; $display("FAIL bypass_rd2_new got=%h exp=%h", rd_dat_2, DA5); end
      checks++; if (rd_dat_0 !== D33) begin errors++; $display("FAIL bypass_rd0_old got=%h exp=%h", rd_dat_0, D33); end
      clr();
      strobe   = 1'b1;
      rd_enb_1 = 1'b1;
      rd_adr_1 = 6'd3;
      tick();
      checks++; if (rd_dat_1 !== DA5) begin errors++; $display("FAIL bypass_next_edge got=%h exp=%h", rd_dat_1, DA5); end
   endtask

   task automatic test_dual_write();
      clr();
      strobe   = 1'b1;
      el_sel   = 1'b1;
      wr_enb_0 = 1'b1;
      wr_adr_0 = 6'd63;
      wr_dat_0 = DA;
      wr_enb_1 = 1'b1;
      wr_adr_1 = 6'd63;
      wr_dat_1 = DB;
      rd_enb_3 = 1'b1;
      rd_adr_3 = 6'd63;
      tick();
      checks++; if (rd_dat_3 !== DA) begin errors++; $display("FAIL dual_same_edge_late got=%h exp=%h", rd_dat_3, DA); end
      clr();
      strobe   = 1'b1;
      el_sel   = 1'b1;
      rd_enb_3 = 1'b1;
      rd_adr_3 = 6'd63;
      tick();
      checks++; if (rd_dat_3 !== DB) begin errors++; $display("FAIL dual_wr1_wins got=%h exp=%h", rd_dat_3, DB); end
   endtask

   task automatic test_strobe_off();
      clr();
      el_sel   = 1'b1;
      rd_enb_0 = 1'b1;
      rd_enb_1 = 1'b1;
      rd_enb_2 = 1'b1;
      rd_enb_3 = 1'b1;
      rd_adr_0 = 6'd4;
      rd_adr_1 = 6'd4;
      rd_adr_2 = 6'd4;
      rd_adr_3 = 6'd4;
      wr_enb_0 = 1'b1;
      wr_adr_0 = 6'd4;
      wr_dat_0 = DFF;
      wr_enb_1 = 1'b1;
      wr_adr_1 = 6'd8;
      wr_dat_1 = DFF;
      tick();
      checks++; if (rd_dat_0 !== D33) begin errors++; $display("FAIL strobe_off_rd0 got=%h exp=%h", rd_dat_0, D33); end
      checks++; if (rd_dat_1 !== DA5) begin errors++; $display("FAIL strobe_off_rd1 got=%h exp=%h", rd_dat_1, DA5); end
      checks++; if (rd_dat_2 !== DA5) begin errors++; $display("FAIL strobe_off_rd2 got=%h exp=%h", rd_dat_2, DA5); end
      checks++; if (rd_dat_3 !== DB)  begin errors++; $display("FAIL strobe_off_rd3 got=%h exp=%h", rd_dat_3, DB); end
      clr();
      strobe   = 1'b1;
      el_sel   = 1'b1;
      rd_enb_0 = 1'b1;
      rd_adr_0 = 6'd4;
      rd_enb_2 = 1'b1;
      rd_adr_2 = 6'd8;
      tick();
      checks++; if (rd_dat_0 !== D04) begin errors++; $display("FAIL strobe_off_mem4 got=%h exp=%h", rd_dat_0, D04); end
      checks++; if (rd_dat_2 !== D08) begin errors++; $display("FAIL strobe_off_mem8 got=%h exp=%h", rd_dat_2, D08); end
   endtask

   task automatic test_hold();
      clr();
      strobe   = 1'b1;
      el_sel   = 1'b1;
      rd_adr_0 = 6'd63;
      rd_adr_1 = 6'd5;
      rd_adr_2 = 6'd3;
      rd_adr_3 = 6'd2;
      tick();
      checks++; if (rd_dat_0 !== D04) begin errors++; $display("FAIL hold_rd0 got=%h exp=%h", rd_dat_0, D04); end
      checks++; if (rd_dat_1 !== DA5) begin errors++; $display("FAIL hold_rd1 got=%h exp=%h", rd_dat_1, DA5); end
      checks++; if (rd_dat_2 !== D08) begin errors++; $display("FAIL hold_rd2 got=%h exp=%h", rd_dat_2, D08); end
      checks++; if (rd_dat_3 !== DB)  begin errors++; $display("FAIL hold_rd3 got=%h exp=%h", rd_dat_3, DB); end
   endtask

   task automatic test_async_reset();
      clr();
      strobe   = 1'b1;
      el_sel   = 1'b1;
      wr_enb_0 = 1'b1;
      wr_adr_0 = 6'd2;
      wr_dat_0 = DFF;
      #2;
      reset = 1'b0;
      #1;
      checks++; if (rd_dat_0 !== '0) begin errors++; $display("FAIL async_rd0 got=%h exp=%h", rd_dat_0, 72'h0); end
      checks++; if (rd_dat_1 !== '0) begin errors++; $display("FAIL async_rd1 got=%h exp=%h", rd_dat_1, 72'h0); end
      checks++; if (rd_dat_2 !== '0) begin errors++; $display("FAIL async_rd2 got=%h exp=%h", rd_dat_2, 72'h0); end
      checks++; if (rd_dat_3 !== '0) begin errors++; $display("FAIL async_rd3 got=%h exp=%h", rd_dat_3, 72'h0); end
      tick();
      reset = 1'b1;
      clr();
      strobe   = 1'b1;
      rd_enb_0 = 1'b1;
      rd_adr_0 = 6'd2;
      tick();
      checks++; if (rd_dat_0 !== D02) begin errors++; $display("FAIL reset_blocks_write got=%h exp=%h", rd_dat_0, D02); end
   endtask

   initial begin
      test_reset();
      test_early_write();
      test_late_suppress();
      test_bypass();
      test_dual_write();
      test_strobe_off();
      test_hold();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
